tp84_ioctl_loader: RTL

// - Upstream of the TP84 core. Demultiplexes the HPS ioctl download stream into per-region ROM write strobes.
// - Captures the DIP-switch bytes and the ROM-set flag.
// - Holds the core in reset (core_reset_n) from download start until SETTLE_CYCLES after the download ends.
// - Replaces the ad-hoc top-level ioctl/DIP decode. Output is registered: one cycle of latency.

---
 rtl/tp84_pkg.sv | 24 ++
 rtl/tp84_region_decode.sv | 24 ++
 rtl/tp84_ioctl_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tp84_pkg.sv
// TP84 ioctl loader shared types: ROM region map, region enum and loader FSM states.
package tp84_pkg;

  localparam int TP84_NUM_REGIONS   = 8;
  localparam int TP84_REG_AW        = 16;
  localparam int TP84_SETTLE_CYCLES = 16;
  localparam int TP84_IOCTL_AW      = 25;

  typedef enum logic [2:0] {
    CPU1, CPU2, SND, CHAR, SPR, PROM_RGB, PROM_LUT, SND_PROM
  } region_e;

  // Ascending bases into the index-0 stream; a byte belongs to the last base at or below it.
  localparam logic [TP84_IOCTL_AW-1:0] REGION_BASE [TP84_NUM_REGIONS] = '{
    25'h00000, 25'h08000, 25'h0A000, 25'h0C000,
    25'h0E000, 25'h16000, 25'h16100, 25'h16200
  };
  localparam logic [TP84_IOCTL_AW-1:0] MAP_END = 25'h16300;

  typedef enum logic [2:0] {
    ST_HOLD, ST_IDLE, ST_LOAD, ST_SETTLE, ST_RUN
  } ld_state_e;

endpackage

// File: rtl/tp84_region_decode.sv
// Combinational index-0 address decode: one-hot region hit, region-relative offset, in-map flag.
module tp84_region_decode
  import tp84_pkg::*;
(
  input  logic [TP84_IOCTL_AW-1:0]    addr,
  output logic [TP84_NUM_REGIONS-1:0] hit,
  output logic [TP84_REG_AW-1:0]      offset,
  output logic                        valid
);

  region_e sel;

  always_comb begin
    sel = CPU1;
    for (int k = 0; k < TP84_NUM_REGIONS; k++) begin
      if (addr >= REGION_BASE[k]) sel = region_e'(k[2:0]);
    end
    valid  = (addr < MAP_END);
    hit    = '0;
    if (valid) hit[sel] = 1'b1;
    offset = TP84_REG_AW'(addr - REGION_BASE[sel]);
  end

endmodule

// File: rtl/tp84_ioctl_loader.sv
// Demultiplexes the HPS ioctl stream into registered ROM write strobes, captures DIP/set bytes,
// and sequences core_reset_n around index-0 downloads. Outputs lag ioctl_wr by one cycle.
module tp84_ioctl_loader
  import tp84_pkg::*;
#(
  parameter int NUM_REGIONS   = TP84_NUM_REGIONS,
  parameter int REG_AW        = TP84_REG_AW,
  parameter int SETTLE_CYCLES = TP84_SETTLE_CYCLES,
  parameter int DIP_INDEX     = 254,
  parameter int SET_INDEX     = 1
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [7:0]             ioctl_index,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  output logic [NUM_REGIONS-1:0] rom_wr,
  output logic [REG_AW-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic [15:0]            dip_sw,
  output logic                   is_set3,
  output logic                   core_reset_n,
  output logic                   loaded,
  output logic [24:0]            byte_count,
  output logic                   map_err
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  ld_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dl_prev_q, dl_prev_d;
  logic [NUM_REGIONS-1:0] rom_wr_q, rom_wr_d;
  logic [REG_AW-1:0]      rom_addr_q, rom_addr_d;
  logic [7:0]             rom_data_q, rom_data_d;
  logic [15:0]            dip_sw_q, dip_sw_d;
  logic                   is_set3_q, is_set3_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   loaded_q, loaded_d;
  logic [24:0]            byte_count_q, byte_count_d;
  logic                   map_err_q, map_err_d;

  logic [NUM_REGIONS-1:0] dec_hit;
  logic [REG_AW-1:0]      dec_offset;
  logic                   dec_valid;
  logic                   is_rom, dl_rise;

  tp84_region_decode u_decode (
    .addr   (ioctl_addr),
    .hit    (dec_hit),
    .offset (dec_offset),
    .valid  (dec_valid)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dl_prev_d    = ioctl_download;
    rom_wr_d     = '0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    dip_sw_d     = dip_sw_q;
    is_set3_d    = is_set3_q;
    core_rst_n_d = core_rst_n_q;
    loaded_d     = loaded_q;
    byte_count_d = byte_count_q;
    map_err_d    = map_err_q;

    is_rom  = (ioctl_index == 8'd0);
    dl_rise = ioctl_download && !dl_prev_q && is_rom;

    case (state_q)
      ST_HOLD, ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d      = ST_RUN;
          core_rst_n_d = 1'b1;
          // Leaving the power-on hold is not a completed download.
          if (state_q == ST_SETTLE) loaded_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          state_d = ST_SETTLE;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
        end
      end
      default: ;
    endcase

    if (dl_rise) begin
      state_d      = ST_LOAD;
      core_rst_n_d = 1'b0;
      byte_count_d = '0;
      map_err_d    = 1'b0;
    end

    // Builds on byte_count_d so a write coincident with the rising edge counts as the first byte.
    if (ioctl_wr && is_rom) begin
      if (dec_valid) begin
        rom_wr_d     = dec_hit;
        rom_addr_d   = dec_offset;
        rom_data_d   = ioctl_dout;
        byte_count_d = (&byte_count_d) ? byte_count_d : byte_count_d + 25'd1;
      end else begin
        map_err_d = 1'b1;
      end
    end

    if (ioctl_wr && ioctl_index == 8'(DIP_INDEX)) begin
      if (ioctl_addr == 25'd0) dip_sw_d[7:0]  = ~ioctl_dout;
      if (ioctl_addr == 25'd1) dip_sw_d[15:8] = ~ioctl_dout;
    end

    if (ioctl_wr && ioctl_index == 8'(SET_INDEX) && ioctl_addr == 25'd0) begin
      is_set3_d = ioctl_dout[0];
    end
  end

  // dl_prev resets high so a download already in flight at reset release is not a new edge.
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      cnt_q        <= CW'(SETTLE_CYCLES - 1);
      dl_prev_q    <= 1'b1;
      rom_wr_q     <= '0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      dip_sw_q     <= 16'hFFFF;
      is_set3_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      loaded_q     <= 1'b0;
      byte_count_q <= '0;
      map_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dl_prev_q    <= dl_prev_d;
      rom_wr_q     <= rom_wr_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      dip_sw_q     <= dip_sw_d;
      is_set3_q    <= is_set3_d;
      core_rst_n_q <= core_rst_n_d;
      loaded_q     <= loaded_d;
      byte_count_q <= byte_count_d;
      map_err_q    <= map_err_d;
    end
  end

  assign rom_wr       = rom_wr_q;
  assign rom_addr     = rom_addr_q;
  assign rom_data     = rom_data_q;
  assign dip_sw       = dip_sw_q;
  assign is_set3      = is_set3_q;
  assign core_reset_n = core_rst_n_q;
  assign loaded       = loaded_q;
  assign byte_count   = byte_count_q;
  assign map_err      = map_err_q;

endmodule
